// File: rtl/sr595_pkg.sv
// Shared constants and helpers for the 74HC595 link receiver.
package sr595_pkg;

    localparam int SR595_WIDTH_DEFAULT = 12;
    localparam int SR595_SYNC_DEFAULT  = 2;

    function automatic int sr595_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sr595_sync_edge.sv
// Multi-flop pin synchronizer with a registered rising-edge detector.
module sr595_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/sr595_rx.sv
// 74HC595 far-end receiver: rebuilds shift stage and storage latch on clk.
module sr595_rx
    import sr595_pkg::*;
#(
    parameter int WIDTH       = SR595_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SR595_SYNC_DEFAULT,
    parameter int CHECK_LEN   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_shcp,
    input  logic                               i_stcp,
    input  logic                               i_ds,
    input  logic                               i_oe,
    output logic [WIDTH-1:0]                   o_data,
    output logic [WIDTH-1:0]                   o_q,
    output logic                               o_valid,
    output logic                               o_oe_active,
    output logic [sr595_cnt_w(WIDTH)-1:0]      o_bit_cnt,
    output logic                               o_frame_err
);

    localparam int             CW       = sr595_cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);

    logic                   shcp_rise;
    logic                   stcp_rise;
    logic                   shcp_lvl_unused;
    logic                   stcp_lvl_unused;
    logic                   oe_level;
    logic                   oe_rise_unused;
    logic [SYNC_STAGES-1:0] ds_q;
    logic                   ds_sync;
    logic [WIDTH-1:0]       shift_reg;

    sr595_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_shcp (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (i_shcp),
        .o_level(shcp_lvl_unused),
        .o_rise (shcp_rise)
    );

    sr595_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stcp (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (i_stcp),
        .o_level(stcp_lvl_unused),
        .o_rise (stcp_rise)
    );

    sr595_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_oe (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (i_oe),
        .o_level(oe_level),
        .o_rise (oe_rise_unused)
    );

    // Same depth as the SHCP path so each bit lines up with its shift edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_q <= '0;
        end else begin
            ds_q <= {ds_q[SYNC_STAGES-2:0], i_ds};
        end
    end

    assign ds_sync     = ds_q[SYNC_STAGES-1];
    assign o_oe_active = ~oe_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            o_data      <= '0;
            o_q         <= '0;
            o_valid     <= 1'b0;
            o_bit_cnt   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid <= stcp_rise;
            o_q     <= o_oe_active ? o_data : '0;
            if (shcp_rise) begin
                shift_reg <= {shift_reg[WIDTH-2:0], ds_sync};
            end
            // Latch reads the pre-shift register when both clocks rise together.
            if (stcp_rise) begin
                o_data    <= shift_reg;
                o_bit_cnt <= shcp_rise ? CW'(1) : '0;
            end else if (shcp_rise && o_bit_cnt != CNT_MAX) begin
                o_bit_cnt <= o_bit_cnt + CW'(1);
            end
            if (CHECK_LEN != 0 && stcp_rise && o_bit_cnt != CNT_FULL) begin
                o_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr595_rx.sv
// Scoreboard bench for sr595_rx: latch events checked against queued expectations.
module tb_sr595_rx;

    typedef struct packed {
        logic [11:0] d;
        logic        err;
        logic        nerr;
        logic [3:0]  cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_shcp;
    logic        i_stcp;
    logic        i_ds;
    logic        i_oe;
    logic [11:0] o_data,  n_data;
    logic [11:0] o_q,     n_q;
    logic        o_valid, n_valid;
    logic        o_oe_active, n_oe_active;
    logic [3:0]  o_bit_cnt, n_bit_cnt;
    logic        o_frame_err, n_frame_err;

    exp_t        sb_q[$];
    int          n_vec;
    int          n_miss;
    logic [11:0] mdl_sr;

    sr595_rx #(.WIDTH(12), .SYNC_STAGES(2), .CHECK_LEN(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_shcp     (i_shcp),
        .i_stcp     (i_stcp),
        .i_ds       (i_ds),
        .i_oe       (i_oe),
        .o_data     (o_data),
        .o_q        (o_q),
        .o_valid    (o_valid),
        .o_oe_active(o_oe_active),
        .o_bit_cnt  (o_bit_cnt),
        .o_frame_err(o_frame_err)
    );

    sr595_rx #(.WIDTH(12), .SYNC_STAGES(2), .CHECK_LEN(0)) u_nochk (
        .clk        (clk),
        .rst        (rst),
        .i_shcp     (i_shcp),
        .i_stcp     (i_stcp),
        .i_ds       (i_ds),
        .i_oe       (i_oe),
        .o_data     (n_data),
        .o_q        (n_q),
        .o_valid    (n_valid),
        .o_oe_active(n_oe_active),
        .o_bit_cnt  (n_bit_cnt),
        .o_frame_err(n_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        i_ds = b;
        wait_clk(4);
        i_shcp = 1'b1;
        wait_clk(4);
        i_shcp = 1'b0;
        mdl_sr = {mdl_sr[10:0], b};
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
    endtask

    task automatic latch(input logic [11:0] d, input logic err,
                         input logic nerr);
        sb_q.push_back('{d: d, err: err, nerr: nerr, cnt: 4'd0});
        i_stcp = 1'b1;
        wait_clk(4);
        i_stcp = 1'b0;
        wait_clk(4);
    endtask

    task automatic tied_bit(input logic b);
        sb_q.push_back('{d: mdl_sr, err: 1'b1, nerr: 1'b0, cnt: 4'd1});
        i_ds = b;
        wait_clk(4);
        i_shcp = 1'b1;
        i_stcp = 1'b1;
        wait_clk(4);
        i_shcp = 1'b0;
        i_stcp = 1'b0;
        mdl_sr = {mdl_sr[10:0], b};
    endtask

    // Monitor: every latch pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && o_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected_valid: got data %0h expected none",
                         o_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data",     32'(o_data),      32'(e.d));
                chk("sb_err",      32'(o_frame_err), 32'(e.err));
                chk("sb_cnt",      32'(o_bit_cnt),   32'(e.cnt));
                chk("sb_nochk_d",  32'(n_data),      32'(e.d));
                chk("sb_nochk_err", 32'(n_frame_err), 32'(e.nerr));
                chk("sb_nochk_vld", 32'(n_valid),    32'd1);
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        mdl_sr = '0;
        rst    = 1'b1;
        i_shcp = 1'b1;
        i_stcp = 1'b1;
        i_ds   = 1'b1;
        i_oe   = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        chk("rst_data",   32'(o_data),      32'h0);
        chk("rst_cnt",    32'(o_bit_cnt),   32'h0);
        chk("rst_err",    32'(o_frame_err), 32'h0);
        chk("rst_oe_act", 32'(o_oe_active), 32'h0);
        chk("rst_q",      32'(o_q),         32'h0);

        i_shcp = 1'b0;
        i_stcp = 1'b0;
        i_ds   = 1'b0;
        i_oe   = 1'b0;
        wait_clk(4);

        send_bits(32'hA5C, 12);
        chk("nom_cnt12", 32'(o_bit_cnt), 32'd12);
        latch(12'hA5C, 1'b0, 1'b0);
        chk("nom_cnt0",   32'(o_bit_cnt),   32'd0);
        chk("nom_q",      32'(o_q),         32'hA5C);
        chk("nom_oe_act", 32'(o_oe_active), 32'h1);

        i_oe = 1'b1;
        wait_clk(4);
        chk("oe_off_act",  32'(o_oe_active), 32'h0);
        chk("oe_off_q",    32'(o_q),         32'h0);
        chk("oe_off_data", 32'(o_data),      32'hA5C);
        i_oe = 1'b0;
        wait_clk(4);
        chk("oe_on_q", 32'(o_q), 32'hA5C);

        send_bits(32'h3AB, 11);
        latch(12'h3AB, 1'b1, 1'b0);

        send_bits(32'h3FFE, 14);
        chk("long_cnt_sat",  32'(o_bit_cnt), 32'd13);
        chk("long_ncnt_sat", 32'(n_bit_cnt), 32'd13);
        latch(12'hFFE, 1'b1, 1'b0);

        send_bits(32'h246, 12);
        for (int i = 11; i >= 0; i--) tied_bit(1'(32'h123 >> i));
        tied_bit(1'b0);
        chk("tied_data", 32'(o_data),    32'h123);
        chk("tied_cnt",  32'(o_bit_cnt), 32'd1);

        send_bits(32'h2B, 6);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        mdl_sr = '0;
        wait_clk(4);
        chk("mid_rst_cnt", 32'(o_bit_cnt),   32'd0);
        chk("mid_rst_err", 32'(o_frame_err), 32'd0);
        send_bits(32'h5A5, 12);
        latch(12'h5A5, 1'b0, 1'b0);
        chk("mid_rst_q", 32'(o_q), 32'h5A5);

        wait_clk(10);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sr595_rx.md
Name: sr595_rx

Overview:
- Clock-domain receiver for the 74HC595 serial protocol (STCP/SHCP/DS/OE), i.e. the far end of the shift-register link.
- Oversamples the four pins on the system clock and rebuilds the shift stage and the storage latch.
- Presents the latched parallel word, a load strobe, the OE-gated outputs and a frame-length check.
- Serves as the loopback checker in board-level tests and as the cycle-accurate 595 model in the display-chain benches.

Parameters:
- WIDTH, 12, number of bits per frame (8 segment bits + 4 anode bits); legal range 2..32.
- SYNC_STAGES, 2, synchronizer flops per input pin; minimum 2.
- CHECK_LEN, 1, 1 = flag a latch that follows a shift count other than WIDTH; 0 = o_frame_err is tied to 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- i_shcp  input  1  shift clock pin; async to clk.
- i_stcp  input  1  storage (latch) clock pin; async to clk.
- i_ds  input  1  serial data pin; async to clk.
- i_oe  input  1  output enable pin, active low; async to clk.
- o_data  output  WIDTH  storage-register contents.
- o_q  output  WIDTH  o_data when OE is asserted, else all zeros (tristate model).
- o_valid  output  1  one-cycle pulse on every latch event.
- o_oe_active  output  1  synchronized, inverted i_oe.
- o_bit_cnt  output  $clog2(WIDTH+2)  SHCP rising edges since the last latch; saturates at WIDTH+1.
- o_frame_err  output  1  sticky flag: a latch occurred with o_bit_cnt != WIDTH.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Synchronizers:
  - Each pin passes through SYNC_STAGES flops.
  - SHCP and STCP each have one further "prev" flop.
  - A rising edge is detected when the last sync stage = 1 and prev = 0.
- Reset values:
  - SHCP/STCP sync and prev flops reset to 1, so a pin that is already high at release gives no false edge.
  - OE sync flops reset to 1 (disabled). DS sync flops reset to 0.
  - Shift register, o_data and o_q reset to 0; o_valid, o_frame_err and o_bit_cnt reset to 0; o_oe_active resets to 0.
- Latency:
  - A pin edge that is sampled high on clk edge k acts on clk edge k+SYNC_STAGES.
  - The register update is visible after that edge.
  - DS is sampled through an identical path, so DS is aligned with its SHCP edge.
- Shift event (SHCP rise): shift_reg <= {shift_reg[WIDTH-2:0], ds_sync}. The first bit shifted ends up in o_data[WIDTH-1], i.e. MSB first.
- Latch event (STCP rise):
  - o_data <= shift_reg.
  - o_valid = 1 for exactly one cycle.
  - o_bit_cnt is cleared.
  - If CHECK_LEN and pre-clear count != WIDTH, o_frame_err <= 1.
- SHCP and STCP rising in the same cycle:
  - The latch captures the pre-shift shift_reg, as the real chip does with tied clocks.
  - The length check uses the pre-shift count.
  - o_bit_cnt then becomes 1.
- Over-length frame: more than WIDTH shifts keeps only the last WIDTH bits. The count saturates at WIDTH+1.
- o_frame_err: cleared only by rst.
- OE: o_oe_active = ~oe_sync. o_q = o_oe_active ? o_data : 0, registered, so it has one cycle of latency after o_data or OE changes.
- Input timing: each high and low phase of SHCP/STCP must last ≥ 2 clk cycles. Shorter pulses are outside the specification and may be missed.
- Reset mid-frame: the partial shift content is discarded. The next frame starts from a count of 0. No o_valid is generated by reset.

Decomposition:
- Package sr595_pkg holds:
  - SR595_WIDTH_DEFAULT = 12.
  - SR595_SYNC_DEFAULT = 2.
  - A function for the count width, $clog2(WIDTH+2).
- Sub-module sr595_sync_edge: parameter SYNC_STAGES and RST_VAL; outputs o_level and o_rise.
  - Instantiated three times, for SHCP, STCP and OE; OE uses level only.
  - DS uses a plain synchronizer of the same depth so that it stays aligned with SHCP.

Test Plan:
- Reset: hold rst for 3 cycles with all pins high -> after release, o_data=0, o_valid never pulses, o_bit_cnt=0, o_frame_err=0, o_oe_active=0.
- Nominal frame: shift 12'hA5C MSB first, SHCP half-period 4 clk, then pulse STCP, i_oe=0 -> o_valid pulses once, o_data=12'hA5C, o_q=12'hA5C, o_frame_err=0, o_bit_cnt returns to 0.
- OE gating: after the frame above, set i_oe=1 -> o_oe_active=0 and o_q=0 within SYNC_STAGES+2 cycles while o_data stays 12'hA5C. Set i_oe=0 -> o_q=12'hA5C again.
- Length errors:
  - Short frame of 11 bits, then latch -> o_frame_err=1.
  - Next, a 14-bit frame of 14'h3FFE -> o_data=12'hFFE, count saturates at 13.
  - With CHECK_LEN=0, the same stimulus leaves o_frame_err=0.
- Tied clocks: drive SHCP and STCP from the same waveform for 13 edges with data 12'h123 followed by one 0 bit -> the final o_data=12'h123 (pre-shift capture), and o_bit_cnt=1 after each latch.
- Reset mid-frame: shift 6 bits, assert rst for 1 cycle, then a full frame of 12'h5A5 plus latch -> o_data=12'h5A5, o_frame_err=0.
